// File: rtl/udp_echo_responder.sv
// udp_echo_responder
//   Store-and-forward UDP echo engine. It accepts datagrams addressed to
//   LISTEN_PORT, buffers the whole payload, and once the frame has completed
//   cleanly sends it back to the sender with the IP addresses and ports
//   swapped. Datagrams that are errored, oversized, addressed to another port,
//   or that arrive while enable=0 are drained and discarded.
//
// Handshakes: every stream (rx header, rx payload, tx header, tx payload)
//   transfers on a rising clk edge where valid && ready are both 1. Once a
//   source raises valid it holds valid and its data stable until ready.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   rx_hdr_*              UDP RX header in (rx_hdr_ready driven here)
//   rx_t*                 UDP RX payload in, 8-bit AXIS with tuser
//   tx_hdr_*, tx_ip_*,    UDP TX header out (tx_hdr_ready driven by sink)
//   tx_source_port ...
//   tx_t*                 UDP TX payload out, 8-bit AXIS with tuser
//   local_ip              source IP placed in echoed datagrams
//   enable                0: every new datagram is dropped (sampled in IDLE)
//   busy                  1 whenever the FSM is not in IDLE
//   echo_count            datagrams fully echoed (wraps)
//   drop_count            datagrams discarded (wraps)
//   state_dbg             current FSM state encoding

module udp_echo_responder #(
    parameter int LISTEN_PORT   = 1234,
    parameter int BUFFER_DEPTH  = 2048,
    parameter int IP_TTL        = 64,
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    // UDP RX header
    input  logic                     rx_hdr_valid,
    output logic                     rx_hdr_ready,
    input  logic [31:0]              rx_ip_source_ip,
    input  logic [15:0]              rx_source_port,
    input  logic [15:0]              rx_dest_port,
    input  logic [15:0]              rx_length,
    // UDP RX payload
    input  logic [7:0]               rx_tdata,
    input  logic                     rx_tvalid,
    output logic                     rx_tready,
    input  logic                     rx_tlast,
    input  logic                     rx_tuser,
    // UDP TX header
    output logic                     tx_hdr_valid,
    input  logic                     tx_hdr_ready,
    output logic [5:0]               tx_ip_dscp,
    output logic [1:0]               tx_ip_ecn,
    output logic [7:0]               tx_ip_ttl,
    output logic [31:0]              tx_ip_source_ip,
    output logic [31:0]              tx_ip_dest_ip,
    output logic [15:0]              tx_source_port,
    output logic [15:0]              tx_dest_port,
    output logic [15:0]              tx_length,
    output logic [15:0]              tx_checksum,
    // UDP TX payload
    output logic [7:0]               tx_tdata,
    output logic                     tx_tvalid,
    input  logic                     tx_tready,
    output logic                     tx_tlast,
    output logic                     tx_tuser,
    // control / status
    input  logic [31:0]              local_ip,
    input  logic                     enable,
    output logic                     busy,
    output logic [COUNTER_WIDTH-1:0] echo_count,
    output logic [COUNTER_WIDTH-1:0] drop_count,
    output logic [2:0]               state_dbg
);

    localparam int AW = $clog2(BUFFER_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(BUFFER_DEPTH);
    localparam logic [16:0]   MAX_LEN = 17'(BUFFER_DEPTH + 8);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        STORE    = 3'd1,
        DROP     = 3'd2,
        SEND_HDR = 3'd3,
        SEND_PAY = 3'd4
    } state_t;

    state_t state, next_state;

    logic [7:0]    mem [BUFFER_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, byte_count;
    logic [31:0]   src_ip_q;
    logic [15:0]   src_port_q;
    logic [7:0]    rd_data;
    logic          rd_valid, rd_last;
    logic          out_valid, out_last;
    logic [7:0]    out_data;

    logic hdr_ok, hdr_fire, store_fire, overflow;
    logic s2_load, rd_issue, echo_done, drop_done;

    assign hdr_ok = enable && (rx_dest_port == 16'(LISTEN_PORT)) &&
                    (rx_length >= 16'd9) && ({1'b0, rx_length} <= MAX_LEN);
    assign overflow   = (wr_ptr == DEPTH_P);
    assign hdr_fire   = (state == IDLE) && rx_hdr_valid && rx_hdr_ready;
    assign store_fire = (state == STORE) && rx_tvalid;
    assign echo_done  = (state == SEND_PAY) && out_valid && tx_tready && out_last;
    // A frame is counted as dropped exactly once, on the tlast that ends it.
    assign drop_done  = ((state == STORE) && rx_tvalid && rx_tlast && (rx_tuser || overflow)) ||
                        ((state == DROP) && rx_tvalid && rx_tlast);

    // Two-stage read pipe: stage 1 is the registered RAM output, stage 2 the
    // output (skid) register. A read is only issued when stage 1 will be free
    // on the next edge, so the RAM register never has to hold a byte. The
    // first byte is prefetched while the header is waiting.
    assign s2_load  = (state == SEND_PAY) && rd_valid && (!out_valid || tx_tready);
    assign rd_issue = ((state == SEND_HDR) || (state == SEND_PAY)) &&
                      (rd_ptr != byte_count) && (!rd_valid || s2_load);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state   = state;
        rx_hdr_ready = 1'b0;
        rx_tready    = 1'b0;
        tx_hdr_valid = 1'b0;
        busy         = 1'b1;
        case (state)
            IDLE: begin
                busy         = 1'b0;
                rx_hdr_ready = reset_n;
                if (rx_hdr_valid && reset_n) next_state = hdr_ok ? STORE : DROP;
            end
            STORE: begin
                rx_tready = 1'b1;
                if (rx_tvalid) begin
                    if (rx_tlast)      next_state = (rx_tuser || overflow) ? IDLE : SEND_HDR;
                    else if (overflow) next_state = DROP;
                end
            end
            DROP: begin
                rx_tready = 1'b1;
                if (rx_tvalid && rx_tlast) next_state = IDLE;
            end
            SEND_HDR: begin
                tx_hdr_valid = 1'b1;
                if (tx_hdr_ready) next_state = SEND_PAY;
            end
            SEND_PAY: begin
                if (echo_done) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Payload RAM: no reset so it maps onto block RAM; read is registered.
    always_ff @(posedge clk) begin
        if (store_fire && !overflow) mem[wr_ptr[AW-1:0]] <= rx_tdata;
        if (rd_issue)                rd_data <= mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            byte_count <= '0;
            src_ip_q   <= '0;
            src_port_q <= '0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            echo_count <= '0;
            drop_count <= '0;
        end else begin
            if (hdr_fire) begin
                src_ip_q   <= rx_ip_source_ip;
                src_port_q <= rx_source_port;
            end
            if (store_fire && !overflow) begin
                wr_ptr <= wr_ptr + PW'(1);
                if (rx_tlast) byte_count <= wr_ptr + PW'(1);
            end
            if (rd_issue) begin
                rd_ptr   <= rd_ptr + PW'(1);
                rd_valid <= 1'b1;
                rd_last  <= ((rd_ptr + PW'(1)) == byte_count);
            end else if (s2_load) begin
                rd_valid <= 1'b0;
            end
            if (s2_load) begin
                out_valid <= 1'b1;
                out_data  <= rd_data;
                out_last  <= rd_last;
            end else if (out_valid && tx_tready) begin
                out_valid <= 1'b0;
            end
            // Leaving any busy state clears the buffer pointers and the read pipe.
            if (state != IDLE && next_state == IDLE) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                rd_valid  <= 1'b0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (echo_done) echo_count <= echo_count + COUNTER_WIDTH'(1);
            if (drop_done) drop_count <= drop_count + COUNTER_WIDTH'(1);
        end
    end

    assign tx_ip_dscp      = '0;
    assign tx_ip_ecn       = '0;
    assign tx_ip_ttl       = 8'(IP_TTL);
    assign tx_checksum     = '0;
    assign tx_ip_source_ip = local_ip;
    assign tx_ip_dest_ip   = src_ip_q;
    assign tx_source_port  = 16'(LISTEN_PORT);
    assign tx_dest_port    = src_port_q;
    assign tx_length       = 16'(byte_count) + 16'd8;

    assign tx_tvalid = out_valid;
    assign tx_tdata  = out_data;
    assign tx_tlast  = out_last;
    assign tx_tuser  = 1'b0;
    assign state_dbg = state;

endmodule
